// File: rtl/vga_scan_fetch.sv
// vga_scan_fetch: 640x480@60 scan-out with framebuffer fetch; VGA_TEST_PATTERN_EN adds an fx^fy test pattern
module vga_scan_fetch #(
  parameter logic [31:0] FB_BASE    = 32'h200,
  parameter int          SCALE_LOG2 = 3,
  parameter logic [9:0]  H_VIS      = 10'd640,
  parameter logic [9:0]  H_FP       = 10'd16,
  parameter logic [9:0]  H_SYNC     = 10'd96,
  parameter logic [9:0]  H_BP       = 10'd48,
  parameter logic [9:0]  V_VIS      = 10'd480,
  parameter logic [9:0]  V_FP       = 10'd10,
  parameter logic [9:0]  V_SYNC     = 10'd2,
  parameter logic [9:0]  V_BP       = 10'd33
) (
  input  logic        clk,
  input  logic        reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_da,
  output logic [7:0]  pixel,
  output logic        frame_start
);
  localparam logic [9:0] H_END  = H_VIS + H_FP + H_SYNC + H_BP - 10'd1;
  localparam logic [9:0] V_END  = V_VIS + V_FP + V_SYNC + V_BP - 10'd1;
  localparam logic [9:0] HS_BEG = H_VIS + H_FP;
  localparam logic [9:0] HS_END = HS_BEG + H_SYNC - 10'd1;
  localparam logic [9:0] VS_BEG = V_VIS + V_FP;
  localparam logic [9:0] VS_END = VS_BEG + V_SYNC - 10'd1;
  localparam logic [9:0] FB_W   = H_VIS >> SCALE_LOG2;
  localparam logic [9:0] FB_H   = V_VIS >> SCALE_LOG2;
  logic [9:0]  h, v, fx, fy;
  logic [31:0] byte_addr;
  logic [1:0]  lane1;
  logic        hs1, vs1, da1, fs1;
  logic [7:0]  pix_nxt;
  always_comb begin
    fx = (h < H_VIS) ? (h >> SCALE_LOG2) : FB_W - 10'd1;
    fy = (v < V_VIS) ? (v >> SCALE_LOG2) : FB_H - 10'd1;
    byte_addr = FB_BASE + 32'(fy) * 32'(FB_W) + 32'(fx);
    mem_addr = {byte_addr[31:2], 2'b00};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= (h == H_END) ? 10'd0 : h + 10'd1;
      if (h == H_END) v <= (v == V_END) ? 10'd0 : v + 10'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lane1 <= '0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      da1 <= 1'b0;
      fs1 <= 1'b0;
    end else begin
      lane1 <= byte_addr[1:0];
      hs1 <= !(h >= HS_BEG && h <= HS_END);
      vs1 <= !(v >= VS_BEG && v <= VS_END);
      da1 <= (h < H_VIS) && (v < V_VIS);
      fs1 <= (h == 10'd0) && (v == 10'd0);
    end
  end
`ifdef VGA_TEST_PATTERN_EN
  logic [7:0] pat1;
  always_ff @(posedge clk)
    if (reset) pat1 <= '0;
    else pat1 <= {2'b00, fx[5:0] ^ fy[5:0]};
  always_comb pix_nxt = !da1 ? 8'h00 : pattern_sel ? pat1 : mem_rdata[{lane1, 3'b000} +: 8];
`else
  always_comb pix_nxt = da1 ? mem_rdata[{lane1, 3'b000} +: 8] : 8'h00;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_da <= 1'b0;
      pixel <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hs <= hs1;
      vga_vs <= vs1;
      vga_da <= da1;
      pixel <= pix_nxt;
      frame_start <= fs1;
    end
  end
endmodule

// File: tb/tb_vga_scan_fetch.sv
// tb_vga_scan_fetch: directed vector bench for vga_scan_fetch, plus a shrunken-timing instance for frame-level counts
module tb_vga_scan_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;
  logic [31:0] mem_addr, mem_rdata, s_addr, s_rdata;
  logic        vga_hs, vga_vs, vga_da, frame_start, s_hs, s_vs, s_da, s_fs;
  logic [7:0]  pixel, s_px;
`ifdef VGA_TEST_PATTERN_EN
  logic pattern_sel = 1'b0;
`endif
  vga_scan_fetch dut (
    .clk(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_da(vga_da), .pixel(pixel), .frame_start(frame_start));
  vga_scan_fetch #(.H_VIS(10'd32), .H_FP(10'd4), .H_SYNC(10'd6), .H_BP(10'd6),
                   .V_VIS(10'd16), .V_FP(10'd2), .V_SYNC(10'd2), .V_BP(10'd3)) u_small (
    .clk(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .mem_addr(s_addr), .mem_rdata(s_rdata), .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_da(s_da), .pixel(s_px), .frame_start(s_fs));
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a == 32'h200) ? 32'h44332211 : {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
  endfunction
  always @(posedge clk) begin
    mem_rdata <= ram_word(mem_addr);
    s_rdata <= ram_word(s_addr);
  end
  logic [9:0] hr, vr, h1, v1, h2, v2;
  logic       ok1, ok2;
  always @(posedge clk) begin
    if (reset) begin
      hr <= 10'd0;
      vr <= 10'd0;
      ok1 <= 1'b0;
      ok2 <= 1'b0;
    end else begin
      hr <= (hr == 10'd799) ? 10'd0 : hr + 10'd1;
      if (hr == 10'd799) vr <= (vr == 10'd524) ? 10'd0 : vr + 10'd1;
      ok1 <= 1'b1;
      ok2 <= ok1;
    end
    h1 <= hr;
    v1 <= vr;
    h2 <= h1;
    v2 <= v1;
  end
  int total = 0;
  int bad = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timeout at %0t", name, $time);
  endtask
  task automatic wait_out(input int v, input int h, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (ok2 && int'(v2) == v && int'(h2) == h) begin
        hit = 1'b1;
        return;
      end
    end
  endtask
  task automatic wait_s0(input int v, input int h, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (int'(vr) == v && int'(hr) == h) begin
        hit = 1'b1;
        return;
      end
    end
  endtask
  typedef struct {
    int v;
    int h;
    logic [7:0] px;
    logic da, hs, vs, fs;
  } vec_t;
  vec_t tbl[16];
  logic [11:0] rst_vec;
  assign rst_vec = {8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
  initial begin
    logic hit;
    int da_cnt, hs_cnt, da_fall, hs_first, n, vs_low, vs_falls;
    logic prev;
    tbl[0]  = '{0, 7, 8'h11, 1, 1, 1, 0};
    tbl[1]  = '{0, 8, 8'h22, 1, 1, 1, 0};
    tbl[2]  = '{0, 16, 8'h33, 1, 1, 1, 0};
    tbl[3]  = '{0, 31, 8'h44, 1, 1, 1, 0};
    tbl[4]  = '{0, 32, 8'h04, 1, 1, 1, 0};
    tbl[5]  = '{0, 639, 8'h4F, 1, 1, 1, 0};
    tbl[6]  = '{0, 640, 8'h00, 0, 1, 1, 0};
    tbl[7]  = '{0, 655, 8'h00, 0, 1, 1, 0};
    tbl[8]  = '{0, 656, 8'h00, 0, 0, 1, 0};
    tbl[9]  = '{0, 751, 8'h00, 0, 0, 1, 0};
    tbl[10] = '{0, 752, 8'h00, 0, 1, 1, 0};
    tbl[11] = '{0, 799, 8'h00, 0, 1, 1, 0};
    tbl[12] = '{3, 5, 8'h11, 1, 1, 1, 0};
    tbl[13] = '{7, 63, 8'h07, 1, 1, 1, 0};
    tbl[14] = '{8, 0, 8'h50, 1, 1, 1, 0};
    tbl[15] = '{8, 100, 8'h5C, 1, 1, 1, 0};
    repeat (5) begin
      @(posedge clk); #1;
      check("reset_outputs", 32'({pixel, vga_da, vga_hs, vga_vs, frame_start}), 32'(rst_vec));
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1 check("fs_edge1", 32'(frame_start), 32'd0);
    @(posedge clk); #1 check("first_pixel", 32'({pixel, vga_da, vga_hs, vga_vs, frame_start}), 32'({8'h11, 4'b1111}));
    @(posedge clk); #1 check("fs_edge3", 32'(frame_start), 32'd0);
    for (int i = 0; i < 16; i++) begin
      wait_out(tbl[i].v, tbl[i].h, hit);
      if (!hit) timeout("vec_wait");
      else check($sformatf("vec%0d_v%0d_h%0d", i, tbl[i].v, tbl[i].h),
                 32'({pixel, vga_da, vga_hs, vga_vs, frame_start}),
                 32'({tbl[i].px, tbl[i].da, tbl[i].hs, tbl[i].vs, tbl[i].fs}));
    end
    wait_s0(9, 0, hit);
    if (!hit) timeout("addr_wait");
    else check("mem_addr_v9_h0", mem_addr, 32'h250);
    wait_s0(9, 640, hit);
    if (!hit) timeout("addr_rng_wait");
    else for (int i = 0; i < 160; i++) begin
      check("addr_in_fb", 32'(mem_addr >= 32'h200 && mem_addr <= 32'h14BF && mem_addr[1:0] == 2'b00), 32'd1);
      @(negedge clk);
    end
    wait_out(12, 0, hit);
    if (!hit) timeout("line_wait");
    else begin
      da_cnt = 0; hs_cnt = 0; da_fall = -1; hs_first = -1;
      for (int i = 0; i < 800; i++) begin
        if (vga_da) da_cnt++;
        else if (da_fall < 0) da_fall = i;
        if (!vga_hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = i;
        end
        @(negedge clk);
      end
      check("da_per_line", 32'(da_cnt), 32'd640);
      check("hs_low_per_line", 32'(hs_cnt), 32'd96);
      check("hs_after_da", 32'(hs_first - da_fall), 32'd16);
      check("hs_start_pixel", 32'(hs_first), 32'd656);
    end
    wait_s0(20, 400, hit);
    if (!hit) timeout("midreset_wait");
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_outputs", 32'({pixel, vga_da, vga_hs, vga_vs, frame_start}), 32'(rst_vec));
    check("midreset_addr", mem_addr, 32'h200);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1 check("mid_fs_edge1", 32'(frame_start), 32'd0);
    @(posedge clk); #1 check("mid_first_pixel", 32'({pixel, vga_da, vga_hs, vga_vs, frame_start}), 32'({8'h11, 4'b1111}));
    @(posedge clk); #1 check("mid_fs_edge3", 32'(frame_start), 32'd0);
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = s_fs;
    end
    if (!hit) timeout("small_fs_wait");
    else begin
      n = 0; vs_low = 0; vs_falls = 0; prev = s_vs; hit = 1'b0;
      for (int i = 0; i < 3000 && !hit; i++) begin
        @(negedge clk);
        n++;
        if (!s_vs) vs_low++;
        if (prev && !s_vs) vs_falls++;
        prev = s_vs;
        hit = s_fs;
      end
      if (!hit) timeout("small_period");
      else begin
        check("frame_period", 32'(n), 32'd1104);
        check("vs_low_cycles", 32'(vs_low), 32'd96);
        check("vs_pulses", 32'(vs_falls), 32'd1);
      end
    end
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = 1'b1;
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    wait_out(0, 0, hit);
    if (!hit) timeout("pat_wait0");
    else check("pattern_0_0", 32'(pixel), 32'h00);
    wait_out(16, 24, hit);
    if (!hit) timeout("pat_wait1");
    else check("pattern_24_16", 32'(pixel), 32'h01);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
